// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Register bank plus per-register write-pending scoreboard serving the
//   decode stage. It provides two combinational read ports with write-back
//   bypass and one write-back port. A pending-write counter per register
//   lets decode stall on read-after-write hazards.
//
// Ports
//   clk                 clock, all state updates on posedge
//   reset               asynchronous active-high reset, clears all state
//   rd_addr1/rd_addr2   read port addresses (decode src_reg1/src_reg2)
//   rd_data1/rd_data2   read port data, combinational, bypassed from WB
//   wr_en/wr_addr/wr_data  write-back port; each write retires one claim
//   claim_en/claim_addr    decode claims a destination (one more in flight)
//   busy1/busy2         pending write outstanding on rd_addr1/rd_addr2
//   stall               busy1 | busy2
//   err                 sticky counter overflow/underflow flag
module regfile_scoreboard #(
    parameter int REG_ADDR = 5,
    parameter int REG_SIZE = 32,
    parameter int CNT_W    = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [REG_ADDR-1:0] rd_addr1,
    input  logic [REG_ADDR-1:0] rd_addr2,
    output logic [REG_SIZE-1:0] rd_data1,
    output logic [REG_SIZE-1:0] rd_data2,
    input  logic                wr_en,
    input  logic [REG_ADDR-1:0] wr_addr,
    input  logic [REG_SIZE-1:0] wr_data,
    input  logic                claim_en,
    input  logic [REG_ADDR-1:0] claim_addr,
    output logic                busy1,
    output logic                busy2,
    output logic                stall,
    output logic                err
);

    localparam int NREG = 1 << REG_ADDR;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [REG_SIZE-1:0] regs [NREG];
    logic [CNT_W-1:0]    cnt  [NREG];

    logic wr_v, claim_v, same, inc, dec, ovf, udf;

    // A register whose last outstanding write is retiring this cycle is
    // reported free, matching the bypassed data already on the read port.
    function automatic logic busy_of(input logic [CNT_W-1:0] c,
                                     input logic             retiring);
        return (c != '0) && !((c == CNT_ONE) && retiring);
    endfunction

    // Register 0 is hard-wired: writes and claims to it are dropped.
    assign wr_v    = wr_en && (wr_addr != '0);
    assign claim_v = claim_en && (claim_addr != '0);

    // A claim and a retire of the same register cancel out.
    assign same = claim_v && wr_v && (claim_addr == wr_addr);
    assign inc  = claim_v && !same;
    assign dec  = wr_v && !same;
    assign ovf  = inc && (cnt[claim_addr] == CNT_MAX);
    assign udf  = dec && (cnt[wr_addr] == '0);

    // Bypass is suppressed during reset so the ports read 0 immediately.
    always_comb begin
        rd_data1 = regs[rd_addr1];
        rd_data2 = regs[rd_addr2];
        if (reset) begin
            rd_data1 = '0;
            rd_data2 = '0;
        end else begin
            if (wr_v && (wr_addr == rd_addr1)) rd_data1 = wr_data;
            if (wr_v && (wr_addr == rd_addr2)) rd_data2 = wr_data;
        end
    end

    assign busy1 = busy_of(cnt[rd_addr1], wr_v && (wr_addr == rd_addr1));
    assign busy2 = busy_of(cnt[rd_addr2], wr_v && (wr_addr == rd_addr2));
    assign stall = busy1 | busy2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_v) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Counters saturate instead of wrapping; any saturation event is
    // latched in err so a lost claim/retire is never silent.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                cnt[i] <= '0;
            end
            err <= 1'b0;
        end else begin
            if (inc && !ovf) cnt[claim_addr] <= cnt[claim_addr] + CNT_ONE;
            if (dec && !udf) cnt[wr_addr]    <= cnt[wr_addr] - CNT_ONE;
            if (ovf || udf)  err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed testbench for regfile_scoreboard.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rd_addr1, rd_addr2, wr_addr, claim_addr;
    logic [31:0] rd_data1, rd_data2, wr_data;
    logic        wr_en, claim_en, busy1, busy2, stall, err;

    int checks = 0;
    int passed = 0;

    regfile_scoreboard #(.REG_ADDR(5), .REG_SIZE(32), .CNT_W(3)) dut (
        .clk(clk), .reset(reset),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .claim_en(claim_en), .claim_addr(claim_addr),
        .busy1(busy1), .busy2(busy2), .stall(stall), .err(err)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs change and outputs are
    // sampled between edges.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; claim_en = 1'b0;
        wr_addr = '0; claim_addr = '0; wr_data = '0;
    endtask

    task automatic test_reset();
        rd_addr1 = 5'd1; rd_addr2 = 5'd2;
        #2;
        checks++;
        if (rd_data1 !== 32'h0 || busy1 !== 1'b0 || stall !== 1'b0 || err !== 1'b0)
            $display("FAIL reset_held: rd_data1=%h busy1=%b stall=%b err=%b, want 0", rd_data1, busy1, stall, err);
        else passed++;
        step();
        reset = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) begin
            rd_addr1 = 5'(i); rd_addr2 = 5'(31 - i);
            #1;
            checks++;
            if (rd_data1 !== 32'h0 || rd_data2 !== 32'h0 || busy1 !== 1'b0 ||
                busy2 !== 1'b0 || stall !== 1'b0 || err !== 1'b0)
                $display("FAIL reset_read[%0d]: d1=%h d2=%h b1=%b b2=%b st=%b err=%b, want all 0",
                         i, rd_data1, rd_data2, busy1, busy2, stall, err);
            else passed++;
        end
    endtask

    task automatic test_bypass();
        claim_en = 1'b1; claim_addr = 5'd5; rd_addr1 = 5'd5;
        step();
        idle();
        #1;
        checks++;
        if (busy1 !== 1'b1) $display("FAIL claim_r5_busy: busy1=%b want 1", busy1);
        else passed++;
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        #1;
        checks++;
        if (rd_data1 !== 32'hDEADBEEF || busy1 !== 1'b0)
            $display("FAIL bypass_r5: rd_data1=%h busy1=%b want deadbeef/0", rd_data1, busy1);
        else passed++;
        step();
        idle();
        #1;
        checks++;
        if (rd_data1 !== 32'hDEADBEEF || busy1 !== 1'b0 || err !== 1'b0)
            $display("FAIL array_r5: rd_data1=%h busy1=%b err=%b want deadbeef/0/0", rd_data1, busy1, err);
        else passed++;
    endtask

    task automatic test_zero();
        rd_addr1 = 5'd0;
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
        claim_en = 1'b1; claim_addr = 5'd0;
        #1;
        checks++;
        if (rd_data1 !== 32'h0) $display("FAIL r0_bypass: rd_data1=%h want 0", rd_data1);
        else passed++;
        step();
        idle();
        #1;
        checks++;
        if (rd_data1 !== 32'h0 || busy1 !== 1'b0 || err !== 1'b0)
            $display("FAIL r0_after: rd_data1=%h busy1=%b err=%b want 0/0/0", rd_data1, busy1, err);
        else passed++;
    endtask

    task automatic test_busy_retire();
        rd_addr1 = 5'd0; rd_addr2 = 5'd7;
        claim_en = 1'b1; claim_addr = 5'd7;
        step();
        step();
        idle();
        #1;
        checks++;
        if (busy2 !== 1'b1 || stall !== 1'b1)
            $display("FAIL r7_claimed: busy2=%b stall=%b want 1/1", busy2, stall);
        else passed++;
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h0000_0077;
        #1;
        checks++;
        if (busy2 !== 1'b1 || rd_data2 !== 32'h77)
            $display("FAIL r7_retire1: busy2=%b rd_data2=%h want 1/77", busy2, rd_data2);
        else passed++;
        step();
        wr_data = 32'h7777_0002;
        #1;
        checks++;
        if (busy2 !== 1'b0 || stall !== 1'b0 || rd_data2 !== 32'h7777_0002)
            $display("FAIL r7_retire2: busy2=%b stall=%b rd_data2=%h want 0/0/77770002", busy2, stall, rd_data2);
        else passed++;
        step();
        idle();
        #1;
        checks++;
        if (busy2 !== 1'b0 || rd_data2 !== 32'h7777_0002 || err !== 1'b0)
            $display("FAIL r7_done: busy2=%b rd_data2=%h err=%b want 0/77770002/0", busy2, rd_data2, err);
        else passed++;
    endtask

    task automatic test_same_cycle();
        rd_addr1 = 5'd3; rd_addr2 = 5'd0;
        claim_en = 1'b1; claim_addr = 5'd3;
        step();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
        #1;
        checks++;
        if (busy1 !== 1'b0 || rd_data1 !== 32'h33)
            $display("FAIL r3_same_cycle: busy1=%b rd_data1=%h want 0/33", busy1, rd_data1);
        else passed++;
        step();
        idle();
        #1;
        checks++;
        if (busy1 !== 1'b1 || rd_data1 !== 32'h33 || err !== 1'b0)
            $display("FAIL r3_count_kept: busy1=%b rd_data1=%h err=%b want 1/33/0", busy1, rd_data1, err);
        else passed++;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h34;
        step();
        idle();
        #1;
        checks++;
        if (busy1 !== 1'b0 || rd_data1 !== 32'h34)
            $display("FAIL r3_drained: busy1=%b rd_data1=%h want 0/34", busy1, rd_data1);
        else passed++;
    endtask

    task automatic test_overflow();
        rd_addr1 = 5'd9;
        claim_en = 1'b1; claim_addr = 5'd9;
        for (int i = 0; i < 7; i++) step();
        checks++;
        if (err !== 1'b0 || busy1 !== 1'b1)
            $display("FAIL r9_seven_claims: err=%b busy1=%b want 0/1", err, busy1);
        else passed++;
        step();
        idle();
        #1;
        checks++;
        if (err !== 1'b1 || busy1 !== 1'b1)
            $display("FAIL r9_overflow: err=%b busy1=%b want 1/1", err, busy1);
        else passed++;
        // Counter should have held at 7: six retires leave it at 1.
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
        for (int i = 0; i < 6; i++) step();
        wr_en = 1'b0;
        #1;
        checks++;
        if (busy1 !== 1'b1) $display("FAIL r9_after6: busy1=%b want 1", busy1);
        else passed++;
        wr_en = 1'b1;
        #1;
        checks++;
        if (busy1 !== 1'b0 || rd_data1 !== 32'h99)
            $display("FAIL r9_last_retire: busy1=%b rd_data1=%h want 0/99", busy1, rd_data1);
        else passed++;
        step();
        idle();
        #1;
        checks++;
        if (busy1 !== 1'b0 || err !== 1'b1)
            $display("FAIL r9_empty: busy1=%b err=%b want 0/1", busy1, err);
        else passed++;
    endtask

    task automatic test_underflow();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (err !== 1'b0) $display("FAIL err_cleared: err=%b want 0", err);
        else passed++;
        rd_addr1 = 5'd4;
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h44;
        step();
        idle();
        #1;
        checks++;
        if (err !== 1'b1 || rd_data1 !== 32'h44 || busy1 !== 1'b0)
            $display("FAIL r4_underflow: err=%b rd_data1=%h busy1=%b want 1/44/0", err, rd_data1, busy1);
        else passed++;
    endtask

    task automatic test_reset_mid();
        rd_addr1 = 5'd2; rd_addr2 = 5'd4;
        claim_en = 1'b1; claim_addr = 5'd2;
        step();
        idle();
        #1;
        checks++;
        if (busy1 !== 1'b1 || err !== 1'b1 || rd_data2 !== 32'h44)
            $display("FAIL r2_claimed: busy1=%b err=%b rd_data2=%h want 1/1/44", busy1, err, rd_data2);
        else passed++;
        reset = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h99;
        #1;
        checks++;
        if (busy1 !== 1'b0 || stall !== 1'b0 || err !== 1'b0 ||
            rd_data1 !== 32'h0 || rd_data2 !== 32'h0)
            $display("FAIL reset_mid: busy1=%b stall=%b err=%b d1=%h d2=%h want all 0",
                     busy1, stall, err, rd_data1, rd_data2);
        else passed++;
        idle();
        step();
        reset = 1'b0;
        #1;
        checks++;
        if (busy1 !== 1'b0 || rd_data1 !== 32'h0 || rd_data2 !== 32'h0 || err !== 1'b0)
            $display("FAIL after_reset: busy1=%b d1=%h d2=%h err=%b want all 0",
                     busy1, rd_data1, rd_data2, err);
        else passed++;
    endtask

    initial begin
        reset = 1'b1;
        rd_addr1 = '0; rd_addr2 = '0;
        idle();
        test_reset();
        test_bypass();
        test_zero();
        test_busy_retire();
        test_same_cycle();
        test_overflow();
        test_underflow();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
